mult_div: RTL and testbench

Multiply/divide unit in the EX stage, beside the ALU: it takes the same forwarded operands A and B and executes mult, multu, div, divu, mthi and mtlo. Results go into architectural HI/LO registers. A multi-cycle Busy window models realistic latency. The hazard unit reads Start and Busy to stall any following HI/LO-using instruction in ID. mfhi/mflo read HI/LO directly; their selection into the EX result belongs to the EX mux, not to this block.

---
 rtl/mult_div_if.sv | 13 +
 rtl/mult_div.sv | 101 ++++++++++
 tb/tb_mult_div.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
// EX-stage multiply/divide bus: forwarded operands, op select and start in, HI/LO and Busy out.
interface mult_div_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output A, B, MDUOp, Start, input Busy, HI, LO);
    modport slave  (input A, B, MDUOp, Start, output Busy, HI, LO);
endinterface

// File: rtl/mult_div.sv
// Multiply/divide unit: computes the result on the accepting edge and holds it
// in hi_tmp/lo_tmp until the Busy window ends, then commits it to HI/LO.
module mult_div #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mult_div_if.slave  bus
);
    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] cnt_reg;
    logic          busy_reg;
    logic          wr_en_reg;
    logic [31:0]   hi_reg, lo_reg, hi_tmp_reg, lo_tmp_reg;

    logic          is_mul, is_div, is_sdiv;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   num, den, q_mag, r_mag, q_res, r_res;

    assign is_mul  = (bus.MDUOp == OP_MULT) || (bus.MDUOp == OP_MULTU);
    assign is_div  = (bus.MDUOp == OP_DIV)  || (bus.MDUOp == OP_DIVU);
    assign is_sdiv = (bus.MDUOp == OP_DIV);

    assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

    // Signed division runs on magnitudes; the zero-divisor guard only keeps the
    // divider defined, since a B=0 result is never committed.
    always_comb begin
        num = bus.A;
        den = bus.B;
        if (is_sdiv) begin
            num = bus.A[31] ? (32'd0 - bus.A) : bus.A;
            den = bus.B[31] ? (32'd0 - bus.B) : bus.B;
        end
        if (den == 32'd0) begin
            den = 32'd1;
        end
        q_mag = num / den;
        r_mag = num % den;
        q_res = q_mag;
        r_res = r_mag;
        if (is_sdiv) begin
            if (bus.A[31] ^ bus.B[31]) q_res = 32'd0 - q_mag;
            if (bus.A[31])             r_res = 32'd0 - r_mag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            wr_en_reg  <= 1'b0;
            hi_reg     <= 32'd0;
            lo_reg     <= 32'd0;
            hi_tmp_reg <= 32'd0;
            lo_tmp_reg <= 32'd0;
        end else if (busy_reg) begin
            // Start and mthi/mtlo are deliberately ignored while in flight.
            cnt_reg <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
                busy_reg <= 1'b0;
                if (wr_en_reg) begin
                    hi_reg <= hi_tmp_reg;
                    lo_reg <= lo_tmp_reg;
                end
            end
        end else if (bus.Start && (is_mul || is_div)) begin
            busy_reg <= 1'b1;
            if (is_mul) begin
                cnt_reg    <= CW'(MULT_CYCLES);
                wr_en_reg  <= 1'b1;
                hi_tmp_reg <= (bus.MDUOp == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
                lo_tmp_reg <= (bus.MDUOp == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
            end else begin
                cnt_reg    <= CW'(DIV_CYCLES);
                wr_en_reg  <= (bus.B != 32'd0);
                hi_tmp_reg <= r_res;
                lo_tmp_reg <= q_res;
            end
        end else if (!bus.Start && bus.MDUOp == OP_MTHI) begin
            hi_reg <= bus.A;
        end else if (!bus.Start && bus.MDUOp == OP_MTLO) begin
            lo_reg <= bus.A;
        end
    end

    assign bus.Busy = busy_reg;
    assign bus.HI   = hi_reg;
    assign bus.LO   = lo_reg;
endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed table, randomized ops against an
// arithmetic reference model, and hand-written busy/reset sequences.
module tb_mult_div;
    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;
    logic [31:0] m_hi, m_lo;

    mult_div_if bus ();
    mult_div #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        start;
        logic [31:0] a, b, hi, lo;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.Start = 1'b0;
        bus.MDUOp = 4'd0;
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        m_hi = 0; m_lo = 0;
        chk("reset_busy", {31'd0, bus.Busy}, 32'd0);
        chk("reset_hi", bus.HI, 32'd0);
        chk("reset_lo", bus.LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one op and check Busy length and HI/LO against the reference model.
    task automatic run_op(input logic [3:0] op, input logic st, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned pu;
        bit     muldiv;
        int     cyc, expc;
        logic [31:0] e_hi, e_lo;
        @(negedge clk);
        bus.MDUOp = op; bus.Start = st; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        idle_inputs();
        e_hi = m_hi; e_lo = m_lo;
        muldiv = st && (op >= 4'd1 && op <= 4'd4);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        expc = 0;
        if (muldiv) begin
            expc = (op <= 4'd2) ? 5 : 10;
            case (op)
                4'd1: begin q = sa * sb; e_hi = q[63:32]; e_lo = q[31:0]; end
                4'd2: begin pu = {32'd0, a} * {32'd0, b}; e_hi = pu[63:32]; e_lo = pu[31:0]; end
                4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; e_hi = r[31:0]; e_lo = q[31:0]; end
                default: if (b != 0) begin e_hi = a % b; e_lo = a / b; end
            endcase
        end else if (!st && op == 4'd5) begin
            e_hi = a;
        end else if (!st && op == 4'd6) begin
            e_lo = a;
        end
        cyc = 0;
        while (bus.Busy && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("op%0d_busy_cycles", op), 32'(cyc), 32'(expc));
        chk($sformatf("op%0d_hi", op), bus.HI, e_hi);
        chk($sformatf("op%0d_lo", op), bus.LO, e_lo);
        m_hi = e_hi; m_lo = e_lo;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        tbl[0] = '{4'd1, 1'b1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
        tbl[1] = '{4'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[2] = '{4'd3, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3] = '{4'd4, 1'b1, 32'd7,        32'd2,        32'd1,        32'd3};
        tbl[4] = '{4'd5, 1'b0, 32'h12345678, 32'd0,        32'h12345678, 32'd3};
        tbl[5] = '{4'd6, 1'b0, 32'h9ABCDEF0, 32'd0,        32'h12345678, 32'h9ABCDEF0};
        tbl[6] = '{4'd3, 1'b1, 32'h00001234, 32'd0,        32'h12345678, 32'h9ABCDEF0};
        tbl[7] = '{4'd3, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};

        reset = 1'b1;
        idle_inputs();
        m_hi = 0; m_lo = 0;
        repeat (2) @(posedge clk);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].op, tbl[i].start, tbl[i].a, tbl[i].b);
            chk($sformatf("tbl%0d_hi", i), bus.HI, tbl[i].hi);
            chk($sformatf("tbl%0d_lo", i), bus.LO, tbl[i].lo);
        end

        // Misuse while busy: a second Start and an mtlo must both be dropped.
        @(negedge clk);
        bus.MDUOp = 4'd3; bus.Start = 1'b1; bus.A = 32'd100; bus.B = 32'd7;
        @(posedge clk); #1;
        idle_inputs();
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            if (!bus.Busy) break;
            @(negedge clk);
            if (k == 2) begin bus.MDUOp = 4'd1; bus.Start = 1'b1; bus.A = 32'd3; bus.B = 32'd5; end
            if (k == 3) begin bus.MDUOp = 4'd6; bus.Start = 1'b0; bus.A = 32'h55; end
            @(posedge clk); #1;
            idle_inputs();
            cyc++;
        end
        chk("misuse_busy_cycles", 32'(cyc), 32'd10);
        chk("misuse_hi", bus.HI, 32'd2);
        chk("misuse_lo", bus.LO, 32'd14);
        m_hi = 32'd2; m_lo = 32'd14;

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            int sel;
            sel = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 17);
            case (sel)
                0: run_op(4'd1, 1'b1, a, b);
                1: run_op(4'd2, 1'b1, a, b);
                2: run_op(4'd3, 1'b1, a, b);
                3: run_op(4'd4, 1'b1, a, b);
                4: run_op(4'd5, 1'b0, a, b);
                5: run_op(4'd6, 1'b0, a, b);
                6: run_op(4'($urandom_range(7, 15)), 1'b1, a, b);
                7: run_op(4'd5, 1'b1, a, b);
                8: run_op(4'($urandom_range(3, 4)), 1'b1, a, 32'd0);
                default: run_op(4'd0, 1'b0, a, b);
            endcase
        end

        // Reset during a mult aborts it; nothing lands afterwards.
        @(negedge clk);
        bus.MDUOp = 4'd1; bus.Start = 1'b1; bus.A = 32'd5; bus.B = 32'd6;
        @(posedge clk); #1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset_busy", {31'd0, bus.Busy}, 32'd0);
        chk("midreset_hi", bus.HI, 32'd0);
        chk("midreset_lo", bus.LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("postreset_busy", {31'd0, bus.Busy}, 32'd0);
        chk("postreset_hi", bus.HI, 32'd0);
        chk("postreset_lo", bus.LO, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
